// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller and its forwarding units.
// FSM encodings, forwarding selects and register index width.
package pipe_hazard_ctrl_pkg;

  localparam int WIDTH_REGMARK = 5;
  localparam int WIDTH_FWD     = 2;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_HALT     = 2'd3
  } hz_state_t;

  localparam logic [WIDTH_FWD-1:0] FWD_RF    = 2'b00;
  localparam logic [WIDTH_FWD-1:0] FWD_EXMEM = 2'b01;
  localparam logic [WIDTH_FWD-1:0] FWD_MEMWB = 2'b10;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-register info in, stall/flush/forward controls out.
// master = pipeline side, slave = hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int WIDTH_REGMARK = pipe_hazard_ctrl_pkg::WIDTH_REGMARK
);
  logic [WIDTH_REGMARK-1:0] id_rs1;
  logic [WIDTH_REGMARK-1:0] id_rs2;
  logic                     id_rs1_use;
  logic                     id_rs2_use;
  logic [WIDTH_REGMARK-1:0] idex_rd;
  logic [WIDTH_REGMARK-1:0] idex_rs1;
  logic [WIDTH_REGMARK-1:0] idex_rs2;
  logic                     idex_regwe;
  logic                     idex_is_load;
  logic                     ex_redirect;
  logic [WIDTH_REGMARK-1:0] exmem_rd;
  logic                     exmem_regwe;
  logic                     exmem_is_load;
  logic                     exmem_dram_req;
  logic                     dram_ready;
  logic [WIDTH_REGMARK-1:0] memwb_rd;
  logic                     memwb_regwe;

  logic        pc_stall;
  logic        ifid_stall;
  logic        ifid_flush;
  logic        idex_stall;
  logic        idex_flush;
  logic        exmem_stall;
  logic        memwb_flush;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        mem_err;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_rs1_use, id_rs2_use, idex_rd, idex_rs1, idex_rs2,
           idex_regwe, idex_is_load, ex_redirect, exmem_rd, exmem_regwe,
           exmem_is_load, exmem_dram_req, dram_ready, memwb_rd, memwb_regwe,
    input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall,
           memwb_flush, fwd_a, fwd_b, mem_err, perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_use, id_rs2_use, idex_rd, idex_rs1, idex_rs2,
           idex_regwe, idex_is_load, ex_redirect, exmem_rd, exmem_regwe,
           exmem_is_load, exmem_dram_req, dram_ready, memwb_rd, memwb_regwe,
    output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall,
           memwb_flush, fwd_a, fwd_b, mem_err, perf_stall_cnt, perf_flush_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Combinational operand-forwarding select for one EX operand; zero latency.
// EX/MEM ALU results win over MEM/WB; loads in EX/MEM and register 0 never forward.
module pipe_fwd_unit #(
  parameter int WIDTH_REGMARK = 5
) (
  input  logic [WIDTH_REGMARK-1:0]                   ex_rs,
  input  logic [WIDTH_REGMARK-1:0]                   exmem_rd,
  input  logic                                       exmem_regwe,
  input  logic                                       exmem_is_load,
  input  logic [WIDTH_REGMARK-1:0]                   memwb_rd,
  input  logic                                       memwb_regwe,
  output logic [pipe_hazard_ctrl_pkg::WIDTH_FWD-1:0] fwd_sel
);
  import pipe_hazard_ctrl_pkg::*;

  always_comb begin
    fwd_sel = FWD_RF;
    if (exmem_regwe && !exmem_is_load && (exmem_rd != '0) && (exmem_rd == ex_rs)) begin
      fwd_sel = FWD_EXMEM;
    end else if (memwb_regwe && (memwb_rd != '0) && (memwb_rd == ex_rs)) begin
      fwd_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage pipeline; controls are combinational from state and inputs.
// PIPE_PERF_CNT_EN adds 32-bit stall-cycle and redirect counters; otherwise they read 0.
module pipe_hazard_ctrl #(
  parameter int WIDTH_REGMARK = pipe_hazard_ctrl_pkg::WIDTH_REGMARK,
  parameter int FLUSH_CYCLES  = 2,
  parameter int MEM_TIMEOUT   = 16
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave hz
);
  import pipe_hazard_ctrl_pkg::*;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] TIMEOUT      = 8'(MEM_TIMEOUT);

  hz_state_t  state;
  logic [2:0] flush_cnt;
  logic [7:0] wait_cnt;
  logic       mem_err_q;

  logic mem_block;
  logic load_use;
  logic freeze;
  logic redirect_take;
  logic flush_on;
  logic lu_stall;
  logic pc_stall;
  logic [WIDTH_FWD-1:0] fwd_a_raw;
  logic [WIDTH_FWD-1:0] fwd_b_raw;

  assign mem_block = hz.exmem_dram_req & ~hz.dram_ready;
  assign load_use  = hz.idex_is_load & hz.idex_regwe & (hz.idex_rd != '0) &
                     ((hz.id_rs1_use & (hz.id_rs1 == hz.idex_rd)) |
                      (hz.id_rs2_use & (hz.id_rs2 == hz.idex_rd)));

  always_comb begin
    freeze        = 1'b0;
    redirect_take = 1'b0;
    flush_on      = 1'b0;
    lu_stall      = 1'b0;
    case (state)
      ST_HALT: freeze = 1'b1;
      ST_MEM_WAIT: begin
        // On release, a held redirect/load-use in ID/EX is acted on unless a flush sequence resumes.
        if (!hz.dram_ready) begin
          freeze = 1'b1;
        end else if (flush_cnt == 3'd0) begin
          redirect_take = hz.ex_redirect;
          lu_stall      = ~hz.ex_redirect & load_use;
        end
      end
      ST_FLUSH: begin
        if (mem_block) freeze = 1'b1;
        else           flush_on = 1'b1;
      end
      default: begin
        if (mem_block)           freeze = 1'b1;
        else if (hz.ex_redirect) redirect_take = 1'b1;
        else                     lu_stall = load_use;
      end
    endcase
    if (rst) begin
      freeze        = 1'b0;
      redirect_take = 1'b0;
      flush_on      = 1'b0;
      lu_stall      = 1'b0;
    end
  end

  assign pc_stall       = freeze | lu_stall;
  assign hz.pc_stall    = pc_stall;
  assign hz.ifid_stall  = freeze | lu_stall;
  assign hz.ifid_flush  = redirect_take | flush_on;
  assign hz.idex_stall  = freeze;
  assign hz.idex_flush  = redirect_take | flush_on | lu_stall;
  assign hz.exmem_stall = freeze;
  assign hz.memwb_flush = freeze;
  assign hz.mem_err     = mem_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      flush_cnt <= 3'd0;
      wait_cnt  <= 8'd0;
      mem_err_q <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_block) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= 8'd1;
          end else if (redirect_take && (FLUSH_CYCLES > 1)) begin
            flush_cnt <= FLUSH_RELOAD;
            state     <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // A memory wait parks flush_cnt; the sequence resumes after release.
          if (mem_block) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= 8'd1;
          end else if (flush_cnt <= 3'd1) begin
            flush_cnt <= 3'd0;
            state     <= ST_RUN;
          end else begin
            flush_cnt <= flush_cnt - 3'd1;
          end
        end
        ST_MEM_WAIT: begin
          if (hz.dram_ready) begin
            wait_cnt <= 8'd0;
            if (flush_cnt != 3'd0) begin
              state <= ST_FLUSH;
            end else if (redirect_take && (FLUSH_CYCLES > 1)) begin
              flush_cnt <= FLUSH_RELOAD;
              state     <= ST_FLUSH;
            end else begin
              state <= ST_RUN;
            end
          end else if (wait_cnt >= TIMEOUT) begin
            state     <= ST_HALT;
            mem_err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= ST_HALT;
      endcase
    end
  end

  pipe_fwd_unit #(.WIDTH_REGMARK(WIDTH_REGMARK)) u_fwd_a (
    .ex_rs         (hz.idex_rs1),
    .exmem_rd      (hz.exmem_rd),
    .exmem_regwe   (hz.exmem_regwe),
    .exmem_is_load (hz.exmem_is_load),
    .memwb_rd      (hz.memwb_rd),
    .memwb_regwe   (hz.memwb_regwe),
    .fwd_sel       (fwd_a_raw)
  );

  pipe_fwd_unit #(.WIDTH_REGMARK(WIDTH_REGMARK)) u_fwd_b (
    .ex_rs         (hz.idex_rs2),
    .exmem_rd      (hz.exmem_rd),
    .exmem_regwe   (hz.exmem_regwe),
    .exmem_is_load (hz.exmem_is_load),
    .memwb_rd      (hz.memwb_rd),
    .memwb_regwe   (hz.memwb_regwe),
    .fwd_sel       (fwd_b_raw)
  );

  assign hz.fwd_a = rst ? FWD_RF : fwd_a_raw;
  assign hz.fwd_b = rst ? FWD_RF : fwd_b_raw;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      if (pc_stall)      perf_stall_q <= perf_stall_q + 32'd1;
      if (redirect_take) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign hz.perf_stall_cnt = perf_stall_q;
  assign hz.perf_flush_cnt = perf_flush_q;
`else
  assign hz.perf_stall_cnt = 32'd0;
  assign hz.perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with FLUSH_CYCLES=2 and MEM_TIMEOUT=4.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  // Control vector order: pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_flush
  localparam logic [6:0] C_NONE   = 7'b0000000;
  localparam logic [6:0] C_FREEZE = 7'b1101011;
  localparam logic [6:0] C_LU     = 7'b1100100;
  localparam logic [6:0] C_FLUSH  = 7'b0010100;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  pipe_hazard_ctrl_if #(.WIDTH_REGMARK(5)) hz ();

  pipe_hazard_ctrl #(
    .WIDTH_REGMARK (5),
    .FLUSH_CYCLES  (2),
    .MEM_TIMEOUT   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  logic [6:0] ctl;
  assign ctl = {hz.pc_stall, hz.ifid_stall, hz.ifid_flush, hz.idex_stall,
                hz.idex_flush, hz.exmem_stall, hz.memwb_flush};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_rs1_use = 1'b0; hz.id_rs2_use = 1'b0;
    hz.idex_rd = '0; hz.idex_rs1 = '0; hz.idex_rs2 = '0;
    hz.idex_regwe = 1'b0; hz.idex_is_load = 1'b0; hz.ex_redirect = 1'b0;
    hz.exmem_rd = '0; hz.exmem_regwe = 1'b0; hz.exmem_is_load = 1'b0;
    hz.exmem_dram_req = 1'b0; hz.dram_ready = 1'b0;
    hz.memwb_rd = '0; hz.memwb_regwe = 1'b0;
  endtask

  task automatic set_load_use();
    hz.idex_is_load = 1'b1; hz.idex_regwe = 1'b1; hz.idex_rd = 5'd5;
    hz.id_rs1 = 5'd5; hz.id_rs1_use = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    set_load_use();
    hz.idex_rs1 = 5'd7; hz.exmem_rd = 5'd7; hz.exmem_regwe = 1'b1;
    #1;
    n_chk++;
    if (ctl !== C_NONE) begin n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl, C_NONE); end
    n_chk++;
    if (hz.fwd_a !== 2'b00) begin n_fail++; $display("FAIL reset_fwd_a: got %b want 00", hz.fwd_a); end
    step();
    n_chk++;
    if (dut.state !== ST_RUN) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dut.state, ST_RUN); end
    n_chk++;
    if (hz.mem_err !== 1'b0) begin n_fail++; $display("FAIL reset_mem_err: got %b want 0", hz.mem_err); end
    n_chk++;
    if ({hz.perf_stall_cnt, hz.perf_flush_cnt} !== 64'd0) begin
      n_fail++; $display("FAIL reset_perf: got %0d/%0d want 0/0", hz.perf_stall_cnt, hz.perf_flush_cnt);
    end
    clear_inputs();
    rst = 1'b0;
    step();
  endtask

  task automatic test_load_use();
    set_load_use();
    #1;
    n_chk++;
    if (ctl !== C_LU) begin n_fail++; $display("FAIL lu_rs1: got %b want %b", ctl, C_LU); end
    step();
    clear_inputs();
    #1;
    n_chk++;
    if (ctl !== C_NONE) begin n_fail++; $display("FAIL lu_bubble: got %b want %b", ctl, C_NONE); end
    n_chk++;
    if (dut.state !== ST_RUN) begin n_fail++; $display("FAIL lu_state: got %0d want %0d", dut.state, ST_RUN); end
    set_load_use();
    hz.idex_rd = 5'd0; hz.id_rs1 = 5'd0;
    #1;
    n_chk++;
    if (ctl !== C_NONE) begin n_fail++; $display("FAIL lu_rd0: got %b want %b", ctl, C_NONE); end
    set_load_use();
    hz.id_rs1_use = 1'b0; hz.id_rs1 = 5'd1; hz.id_rs2 = 5'd5; hz.id_rs2_use = 1'b1;
    #1;
    n_chk++;
    if (ctl !== C_LU) begin n_fail++; $display("FAIL lu_rs2: got %b want %b", ctl, C_LU); end
    hz.id_rs2_use = 1'b0;
    #1;
    n_chk++;
    if (ctl !== C_NONE) begin n_fail++; $display("FAIL lu_unused: got %b want %b", ctl, C_NONE); end
    clear_inputs();
    step();
  endtask

  task automatic test_mem_wait();
    hz.exmem_dram_req = 1'b1; hz.dram_ready = 1'b1;
    #1;
    n_chk++;
    if (ctl !== C_NONE) begin n_fail++; $display("FAIL mem_ready_now: got %b want %b", ctl, C_NONE); end
    hz.dram_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++;
      if (ctl !== C_FREEZE) begin n_fail++; $display("FAIL mem_wait_c%0d: got %b want %b", i, ctl, C_FREEZE); end
      step();
    end
    hz.dram_ready = 1'b1;
    #1;
    n_chk++;
    if (ctl !== C_NONE) begin n_fail++; $display("FAIL mem_release: got %b want %b", ctl, C_NONE); end
    step();
    clear_inputs();
    #1;
    n_chk++;
    if (dut.state !== ST_RUN) begin n_fail++; $display("FAIL mem_state: got %0d want %0d", dut.state, ST_RUN); end
  endtask

  task automatic test_timeout();
    hz.exmem_dram_req = 1'b1; hz.dram_ready = 1'b0;
    // One entry cycle plus four MEM_WAIT cycles, all frozen, before HALT.
    for (int i = 0; i < 5; i++) begin
      #1;
      n_chk++;
      if (ctl !== C_FREEZE || hz.mem_err !== 1'b0) begin
        n_fail++; $display("FAIL timeout_wait_c%0d: got %b err %b want %b err 0", i, ctl, hz.mem_err, C_FREEZE);
      end
      step();
    end
    n_chk++;
    if (dut.state !== ST_HALT) begin n_fail++; $display("FAIL timeout_state: got %0d want %0d", dut.state, ST_HALT); end
    hz.dram_ready = 1'b1; hz.exmem_dram_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++;
      if (ctl !== C_FREEZE || hz.mem_err !== 1'b1) begin
        n_fail++; $display("FAIL halt_hold_c%0d: got %b err %b want %b err 1", i, ctl, hz.mem_err, C_FREEZE);
      end
      step();
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if (ctl !== C_NONE) begin n_fail++; $display("FAIL halt_rst_ctl: got %b want %b", ctl, C_NONE); end
    step();
    rst = 1'b0;
    clear_inputs();
    #1;
    n_chk++;
    if (hz.mem_err !== 1'b0 || dut.state !== ST_RUN) begin
      n_fail++; $display("FAIL halt_cleared: got err %b state %0d want err 0 state %0d", hz.mem_err, dut.state, ST_RUN);
    end
    step();
  endtask

  task automatic test_redirect();
    hz.ex_redirect = 1'b1;
    #1;
    n_chk++;
    if (ctl !== C_FLUSH) begin n_fail++; $display("FAIL redir_c0: got %b want %b", ctl, C_FLUSH); end
    step();
    hz.ex_redirect = 1'b0;
    set_load_use();
    #1;
    n_chk++;
    if (ctl !== C_FLUSH) begin n_fail++; $display("FAIL redir_c1: got %b want %b", ctl, C_FLUSH); end
    step();
    clear_inputs();
    #1;
    n_chk++;
    if (ctl !== C_NONE || dut.state !== ST_RUN) begin
      n_fail++; $display("FAIL redir_end: got %b state %0d want %b state %0d", ctl, dut.state, C_NONE, ST_RUN);
    end

    hz.ex_redirect = 1'b1;
    #1;
    n_chk++;
    if (ctl !== C_FLUSH) begin n_fail++; $display("FAIL redir_w_c0: got %b want %b", ctl, C_FLUSH); end
    step();
    hz.ex_redirect = 1'b0;
    hz.exmem_dram_req = 1'b1; hz.dram_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_chk++;
      if (ctl !== C_FREEZE) begin n_fail++; $display("FAIL redir_w_freeze%0d: got %b want %b", i, ctl, C_FREEZE); end
      step();
    end
    hz.dram_ready = 1'b1;
    #1;
    n_chk++;
    if (ctl !== C_NONE) begin n_fail++; $display("FAIL redir_w_release: got %b want %b", ctl, C_NONE); end
    step();
    clear_inputs();
    #1;
    n_chk++;
    if (ctl !== C_FLUSH) begin n_fail++; $display("FAIL redir_w_resume: got %b want %b", ctl, C_FLUSH); end
    step();
    n_chk++;
    if (ctl !== C_NONE || dut.state !== ST_RUN) begin
      n_fail++; $display("FAIL redir_w_end: got %b state %0d want %b state %0d", ctl, dut.state, C_NONE, ST_RUN);
    end
  endtask

  task automatic test_forwarding();
    hz.idex_rs1 = 5'd7; hz.idex_rs2 = 5'd7;
    hz.exmem_rd = 5'd7; hz.exmem_regwe = 1'b1; hz.exmem_is_load = 1'b0;
    hz.memwb_rd = 5'd7; hz.memwb_regwe = 1'b1;
    #1;
    n_chk++;
    if (hz.fwd_a !== 2'b01 || hz.fwd_b !== 2'b01) begin
      n_fail++; $display("FAIL fwd_exmem: got %b/%b want 01/01", hz.fwd_a, hz.fwd_b);
    end
    hz.exmem_is_load = 1'b1;
    #1;
    n_chk++;
    if (hz.fwd_a !== 2'b10) begin n_fail++; $display("FAIL fwd_load_memwb: got %b want 10", hz.fwd_a); end
    hz.exmem_is_load = 1'b0; hz.idex_rs2 = 5'd3; hz.memwb_rd = 5'd3;
    #1;
    n_chk++;
    if (hz.fwd_a !== 2'b01 || hz.fwd_b !== 2'b10) begin
      n_fail++; $display("FAIL fwd_split: got %b/%b want 01/10", hz.fwd_a, hz.fwd_b);
    end
    hz.memwb_regwe = 1'b0;
    #1;
    n_chk++;
    if (hz.fwd_b !== 2'b00) begin n_fail++; $display("FAIL fwd_no_we: got %b want 00", hz.fwd_b); end
    hz.idex_rs1 = 5'd0; hz.idex_rs2 = 5'd0; hz.exmem_rd = 5'd0; hz.memwb_rd = 5'd0;
    hz.memwb_regwe = 1'b1;
    #1;
    n_chk++;
    if (hz.fwd_a !== 2'b00 || hz.fwd_b !== 2'b00) begin
      n_fail++; $display("FAIL fwd_r0: got %b/%b want 00/00", hz.fwd_a, hz.fwd_b);
    end
    clear_inputs();
    step();
  endtask

  task automatic test_reset_mid_wait();
    hz.exmem_dram_req = 1'b1; hz.dram_ready = 1'b0;
    step();
    step();
    n_chk++;
    if (dut.state !== ST_MEM_WAIT) begin n_fail++; $display("FAIL rmw_in_wait: got %0d want %0d", dut.state, ST_MEM_WAIT); end
    rst = 1'b1;
    hz.idex_rs1 = 5'd9; hz.memwb_rd = 5'd9; hz.memwb_regwe = 1'b1;
    #1;
    n_chk++;
    if (ctl !== C_NONE || hz.fwd_a !== 2'b00) begin
      n_fail++; $display("FAIL rmw_during_rst: got %b fwd %b want %b fwd 00", ctl, hz.fwd_a, C_NONE);
    end
    step();
    rst = 1'b0;
    clear_inputs();
    #1;
    n_chk++;
    if (dut.state !== ST_RUN || dut.wait_cnt !== 8'd0 || dut.flush_cnt !== 3'd0) begin
      n_fail++; $display("FAIL rmw_after: got state %0d wait %0d flush %0d want %0d/0/0",
                         dut.state, dut.wait_cnt, dut.flush_cnt, ST_RUN);
    end
    n_chk++;
    if ({hz.perf_stall_cnt, hz.perf_flush_cnt} !== 64'd0 || ctl !== C_NONE) begin
      n_fail++; $display("FAIL rmw_perf_ctl: got %0d/%0d ctl %b want 0/0 ctl %b",
                         hz.perf_stall_cnt, hz.perf_flush_cnt, ctl, C_NONE);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_load_use();
    test_mem_wait();
    test_timeout();
    test_redirect();
    test_forwarding();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
